decoder_scan_ctrl: RTL and testbench

- Sequential scan controller placed directly upstream of the 3-to-8 behavioural decoder.
- Drives the decoder's a, b, c select inputs and its en input so that the 8 one-hot outputs (display digit strobes / channel selects) are time-multiplexed.
- Scans only the channels enabled in ch_mask, with a programmable dwell time per channel and a blanking gap between channels to prevent ghosting.
- Supports continuous scanning and single-frame (one-shot) scanning.

---
 rtl/decoder_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: drives a/b/c/en of a 3-to-8 decoder to time-multiplex the channels set in ch_mask.
// Optional: define SCAN_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module decoder_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       oneshot,
  input  logic [7:0] ch_mask,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       en,
  output logic       busy,
  output logic       frame_done
`ifdef SCAN_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_e;

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_M1 = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             oneshot_q, oneshot_d;
  logic             start_ok, adv, go_idle;
  logic [3:0]       nxt;

  function automatic logic [2:0] lowest_ch(input logic [7:0] mask);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) lowest_ch = 3'(i);
    end
  endfunction

  // Returns {wrapped, index}: next set bit strictly above cur, else the lowest set bit.
  function automatic logic [3:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = lowest_ch(mask);
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return {~found, idx};
  endfunction

  assign start_ok = (state_q == S_IDLE) && start && !stop && (ch_mask != 8'h00);
  assign nxt      = next_ch(ch_mask, sel_q);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    en_d         = en_q;
    busy_d       = busy_q;
    oneshot_d    = oneshot_q;
    frame_done_d = 1'b0;
    adv          = 1'b0;
    go_idle      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d   = S_ACTIVE;
          oneshot_d = oneshot;
          sel_d     = lowest_ch(ch_mask);
          en_d      = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      S_ACTIVE: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (cnt_q == DWELL_M1) begin
          if (BLANK > 0) begin
            state_d = S_BLANK;
            en_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BLANK: begin
        if (stop) go_idle = 1'b1;
        else if (cnt_q == BLANK_M1) adv = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: go_idle = 1'b1;
    endcase

    // Mask is sampled live here; an empty mask abandons the scan without completing a frame.
    if (adv) begin
      if (ch_mask == 8'h00) begin
        go_idle = 1'b1;
      end else if (nxt[3] && oneshot_q) begin
        go_idle      = 1'b1;
        frame_done_d = 1'b1;
      end else begin
        state_d      = S_ACTIVE;
        sel_d        = nxt[2:0];
        en_d         = 1'b1;
        cnt_d        = '0;
        frame_done_d = nxt[3];
      end
    end

    if (go_idle) begin
      state_d = S_IDLE;
      sel_d   = 3'd0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      oneshot_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      oneshot_q    <= oneshot_d;
    end
  end

  assign {a, b, c}  = sel_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef SCAN_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (start_ok) frame_cnt_d = 8'd0;
    else if (frame_done_d) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= 8'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: scoreboard bench for decoder_scan_ctrl (BLANK=1 and BLANK=0 instances).
// Frame counter checks are included when SCAN_FRAME_CNT_EN is defined.
module tb_decoder_scan_ctrl;

  typedef struct packed {
    logic       en;
    logic       busy;
    logic [2:0] sel;
    logic       fd;
  } obs_t;

  logic       clk, rst_n, start, stop, oneshot, use0;
  logic [7:0] ch_mask;
  logic       start1, start0;
  logic       a1, b1, c1, en1, busy1, fd1;
  logic       a0, b0, c0, en0, busy0, fd0;
  obs_t       obs;
  logic [7:0] y;
  obs_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
`ifdef SCAN_FRAME_CNT_EN
  logic [7:0] fc1, fc0, fc;
`endif

  assign start1 = start & ~use0;
  assign start0 = start & use0;

  decoder_scan_ctrl #(.DWELL(4), .BLANK(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop), .oneshot(oneshot),
    .ch_mask(ch_mask), .a(a1), .b(b1), .c(c1), .en(en1), .busy(busy1), .frame_done(fd1)
`ifdef SCAN_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  decoder_scan_ctrl #(.DWELL(4), .BLANK(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop), .oneshot(oneshot),
    .ch_mask(ch_mask), .a(a0), .b(b0), .c(c0), .en(en0), .busy(busy0), .frame_done(fd0)
`ifdef SCAN_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  always_comb begin
    obs = use0 ? {en0, busy0, a0, b0, c0, fd0} : {en1, busy1, a1, b1, c1, fd1};
    y   = obs.en ? (8'h01 << obs.sel) : 8'h00;
`ifdef SCAN_FRAME_CNT_EN
    fc  = use0 ? fc0 : fc1;
`endif
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference trace: each enabled channel gets dwell cycles with en=1 then blank cycles with
  // en=0; frame_done shows on the first cycle after a full pass; oneshot idles after one pass.
  task automatic gen(input logic [7:0] mask, input bit os, input int dwell, input int blank,
                     input int n);
    int   chs[$];
    obs_t e;
    bit   fd_pend = 0;
    bit   done = 0;
    int   pushed = 0;
    for (int i = 0; i < 8; i++) if (mask[i]) chs.push_back(i);
    while (pushed < n) begin
      if (done) begin
        e = '0;
        e.fd = fd_pend;
        fd_pend = 0;
        sb.push_back(e);
        pushed++;
      end else begin
        foreach (chs[j]) begin
          for (int t = 0; t < dwell + blank; t++) begin
            if (pushed < n) begin
              e.en = (t < dwell);
              e.busy = 1'b1;
              e.sel = 3'(chs[j]);
              e.fd = fd_pend;
              fd_pend = 0;
              sb.push_back(e);
              pushed++;
            end
          end
        end
        fd_pend = 1;
        if (os) done = 1;
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back('0);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (obs !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_hold got=%b want=%b", obs, obs_t'(0));
    end
`ifdef SCAN_FRAME_CNT_EN
    n_cmp++;
    if (fc !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_frame_cnt got=%0d want=0", fc);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_release got=%b want=%b", obs, obs_t'(0));
    end
  endtask

  task automatic test_full_scan();
    obs_t       e;
    logic [7:0] exp_y;
    ch_mask = 8'hFF; oneshot = 1'b0;
    gen(8'hFF, 0, 4, 1, 80);
    start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      exp_y = e.en ? (8'h01 << e.sel) : 8'h00;
      n_cmp += 2;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL full_scan k=%0d got=%b want=%b", k, obs, e);
      end
      if (y !== exp_y) begin
        n_bad++;
        $display("FAIL full_scan_y k=%0d got=%h want=%h", k, y, exp_y);
      end
      start = 1'b0;
    end
    stop = 1'b1;
    push_idle(2);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL full_scan_stop k=%0d got=%b want=%b", k, obs, e);
      end
      stop = 1'b0;
    end
  endtask

  task automatic test_oneshot();
    obs_t e;
    ch_mask = 8'b1010_0100; oneshot = 1'b1;
    gen(8'b1010_0100, 1, 4, 1, 19);
    start = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL oneshot k=%0d got=%b want=%b", k, obs, e);
      end
      start = 1'b0;
      oneshot = 1'b0;
    end
  endtask

  task automatic test_stop();
    obs_t e;
    ch_mask = 8'hFF; oneshot = 1'b0;
    gen(8'hFF, 0, 4, 1, 17);
    start = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL stop_pre k=%0d got=%b want=%b", k, obs, e);
      end
      start = 1'b0;
    end
    stop = 1'b1;
    push_idle(4);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL stop_idle k=%0d got=%b want=%b", k, obs, e);
      end
      stop = 1'b0;
    end
    start = 1'b1; stop = 1'b1;
    push_idle(3);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL start_stop_idle k=%0d got=%b want=%b", k, obs, e);
      end
      start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic test_no_blank();
    obs_t e;
    use0 = 1'b1;
    ch_mask = 8'h10; oneshot = 1'b0;
    gen(8'h10, 0, 4, 0, 20);
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL no_blank k=%0d got=%b want=%b", k, obs, e);
      end
      start = 1'b0;
    end
    stop = 1'b1;
    push_idle(2);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL no_blank_stop k=%0d got=%b want=%b", k, obs, e);
      end
      stop = 1'b0;
    end
    use0 = 1'b0;
  endtask

  task automatic test_mask_drop();
    obs_t e;
    ch_mask = 8'hFF; oneshot = 1'b0;
    gen(8'hFF, 0, 4, 1, 10);
    push_idle(4);
    start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL mask_drop k=%0d got=%b want=%b", k, obs, e);
      end
      start = 1'b0;
      if (k == 6) ch_mask = 8'h00;
    end
    start = 1'b1;
    push_idle(3);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL empty_mask_start k=%0d got=%b want=%b", k, obs, e);
      end
      start = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    ch_mask = 8'hFF; oneshot = 1'b0;
    gen(8'hFF, 0, 4, 1, 3);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL async_pre k=%0d got=%b want=%b", k, obs, e);
      end
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset got=%b want=%b", obs, obs_t'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL async_release got=%b want=%b", obs, obs_t'(0));
    end
  endtask

`ifdef SCAN_FRAME_CNT_EN
  task automatic test_frame_cnt();
    obs_t       e;
    logic [7:0] exp_fc = 8'd0;
    use0 = 1'b1;
    ch_mask = 8'h10; oneshot = 1'b0;
    gen(8'h10, 0, 4, 0, 1025);
    start = 1'b1;
    for (int k = 0; k < 1025; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      if (e.fd) exp_fc = exp_fc + 8'd1;
      n_cmp += 2;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL frame_cnt_trace k=%0d got=%b want=%b", k, obs, e);
      end
      if (fc !== exp_fc) begin
        n_bad++;
        $display("FAIL frame_cnt k=%0d got=%0d want=%0d", k, fc, exp_fc);
      end
      start = 1'b0;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    use0 = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; use0 = 1'b0; ch_mask = 8'h00;
    test_reset();
    test_full_scan();
    test_oneshot();
    test_stop();
    test_no_blank();
    test_mask_drop();
    test_async_reset();
`ifdef SCAN_FRAME_CNT_EN
    test_frame_cnt();
`endif
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
